// File: rtl/acc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : acc_pkg
//  Description : Shared opcodes, ALU select codes and FSM states for the
//                accumulator sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package acc_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_CLR = 3'd1,
        OP_ADD = 3'd2,
        OP_SUB = 3'd3,
        OP_LD  = 3'd4,
        OP_MUL = 3'd5
    } op_t;

    localparam logic [1:0] ALU_CLR  = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        MUL_ADD = 2'd2,
        RESP    = 2'd3
    } state_t;

    function automatic logic op_legal(input logic [2:0] op);
        return (op <= OP_MUL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/acc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : acc_sequencer
//  Description : Command-driven accumulator controller sequencing an external
//                combinational ALU, including shift-free multiply by repeated add.
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_sequencer
    import acc_pkg::*;
#(
    parameter int W  = 16,
    parameter int KW = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [W-1:0] cmd_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_err,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [1:0]   alu_sel,
    input  logic [W-1:0] alu_out,
    output logic [W-1:0] acc
);

    state_t         r_state;
    logic [2:0]     r_op;
    logic [W-1:0]   r_data;
    logic [KW-1:0]  r_cnt;
    logic [W-1:0]   r_mcand;
    logic [W-1:0]   r_acc;
    logic           r_rsp_valid;
    logic [W-1:0]   r_rsp_data;
    logic           r_rsp_err;

    // Reset gates ready so nothing is accepted while the block is being cleared.
    assign cmd_ready = (r_state == IDLE) && !rst;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign acc       = r_acc;

    // ALU controls depend only on registered state, never on the cmd_* inputs.
    always_comb begin
        alu_sel = ALU_PASS;
        alu_a   = r_acc;
        alu_b   = '0;
        case (r_state)
            EXEC: begin
                case (r_op)
                    OP_CLR: alu_sel = ALU_CLR;
                    OP_ADD: begin
                        alu_sel = ALU_ADD;
                        alu_b   = r_data;
                    end
                    OP_SUB: begin
                        alu_sel = ALU_SUB;
                        alu_b   = r_data;
                    end
                    OP_LD:  alu_a   = r_data;
                    OP_MUL: alu_sel = ALU_CLR;
                    default: alu_sel = ALU_PASS;
                endcase
            end
            MUL_ADD: begin
                alu_sel = ALU_ADD;
                alu_b   = r_mcand;
            end
            default: alu_sel = ALU_PASS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_op        <= OP_NOP;
            r_data      <= '0;
            r_cnt       <= '0;
            r_mcand     <= '0;
            r_acc       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_op   <= cmd_op;
                        r_data <= cmd_data;
                        if (cmd_op == OP_MUL) begin
                            r_cnt   <= cmd_data[KW-1:0];
                            r_mcand <= r_acc;
                        end
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_acc <= alu_out;
                    if ((r_op == OP_MUL) && (r_cnt != '0)) begin
                        r_state <= MUL_ADD;
                    end else begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= alu_out;
                        r_rsp_err   <= !op_legal(r_op);
                    end
                end
                MUL_ADD: begin
                    r_acc <= alu_out;
                    r_cnt <= r_cnt - KW'(1);
                    if (r_cnt == KW'(1)) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= alu_out;
                        r_rsp_err   <= 1'b0;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_acc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acc_sequencer
//  Description : Scoreboard bench for acc_sequencer with a behavioural ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_sequencer;
    import acc_pkg::*;

    localparam int W      = 16;
    localparam int KW     = 8;
    localparam int PERIOD = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_err;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [1:0]   alu_sel;
    logic [W-1:0] alu_out;
    logic [W-1:0] acc;

    typedef struct {
        logic [W-1:0] data;
        logic         err;
        int           lat;
        longint       t_acc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #(PERIOD/2) clk = ~clk;

    always_comb begin
        case (alu_sel)
            2'b00:   alu_out = '0;
            2'b01:   alu_out = alu_a + alu_b;
            2'b10:   alu_out = alu_a - alu_b;
            default: alu_out = alu_a;
        endcase
    end

    acc_sequencer #(.W(W), .KW(KW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .acc(acc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, need 0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per response and checks it stays stable.
    logic seen = 1'b0;
    exp_t cur;
    always @(negedge clk) begin
        if (rst !== 1'b0 || rsp_valid !== 1'b1) begin
            seen = 1'b0;
        end else if (!seen) begin
            seen = 1'b1;
            if (q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_data), 32'hDEAD);
            end else begin
                cur = q.pop_front();
                chk("rsp_data", 32'(rsp_data), 32'(cur.data));
                chk("rsp_err", 32'(rsp_err), 32'(cur.err));
                chk("rsp_latency", 32'(($time - cur.t_acc) / PERIOD + 1), 32'(cur.lat));
            end
        end else begin
            chk("rsp_data_hold", 32'(rsp_data), 32'(cur.data));
            chk("rsp_err_hold", 32'(rsp_err), 32'(cur.err));
            chk("acc_hold", 32'(acc), 32'(cur.data));
        end
    end

    task automatic wait_accept(input logic [W-1:0] exp, input logic err, input int lat,
                               input bit push);
        int n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (push) q.push_back('{data: exp, err: err, lat: lat, t_acc: $time});
        #1 cmd_valid = 1'b0;
    endtask

    task automatic send(input logic [2:0] op, input logic [W-1:0] d,
                        input logic [W-1:0] exp, input logic err, input int lat);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        wait_accept(exp, err, lat, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || rsp_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #(PERIOD * 20000);
        $display("FAIL watchdog: got timeout, need completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_data  = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_acc", 32'(acc), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        #1 chk("release_cmd_ready", 32'(cmd_ready), 32'd1);

        // Basic arithmetic and wrap-around
        send(OP_LD,  16'h1234, 16'h1234, 1'b0, 2);
        send(OP_SUB, 16'h0235, 16'h0FFF, 1'b0, 2);
        send(OP_LD,  16'h0001, 16'h0001, 1'b0, 2);
        send(OP_SUB, 16'h0002, 16'hFFFF, 1'b0, 2);
        send(OP_ADD, 16'h0001, 16'h0000, 1'b0, 2);
        send(OP_LD,  16'h0055, 16'h0055, 1'b0, 2);
        send(OP_CLR, 16'h7777, 16'h0000, 1'b0, 2);

        // Multiply: 0x13*5, wrap to zero, and k=0
        send(OP_LD,  16'h0013, 16'h0013, 1'b0, 2);
        send(OP_MUL, 16'h0005, 16'h005F, 1'b0, 7);
        send(OP_LD,  16'h1000, 16'h1000, 1'b0, 2);
        send(OP_MUL, 16'h0010, 16'h0000, 1'b0, 18);
        send(OP_LD,  16'h0007, 16'h0007, 1'b0, 2);
        send(OP_MUL, 16'hAB00, 16'h0000, 1'b0, 2);
        send(OP_LD,  16'h0101, 16'h0101, 1'b0, 2);
        send(OP_MUL, 16'h0003, 16'h0303, 1'b0, 5);
        drain();

        // Back-pressure: second command must wait until the response is taken
        send(OP_LD, 16'h0100, 16'h0100, 1'b0, 2);
        drain();
        rsp_ready = 1'b0;
        send(OP_ADD, 16'h0023, 16'h0123, 1'b0, 2);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_LD;
        cmd_data  = 16'h0BEE;
        repeat (10) begin
            @(negedge clk);
            chk("held_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        wait_accept(16'h0BEE, 1'b0, 2, 1'b1);
        drain();

        // Illegal opcodes leave acc untouched and flag an error
        send(OP_LD,  16'h00AA, 16'h00AA, 1'b0, 2);
        send(3'd7,   16'h1234, 16'h00AA, 1'b1, 2);
        send(OP_NOP, 16'h5555, 16'h00AA, 1'b0, 2);
        send(3'd6,   16'h0001, 16'h00AA, 1'b1, 2);
        send(OP_ADD, 16'h0001, 16'h00AB, 1'b0, 2);
        drain();

        // Reset during the 4th multiply-add cycle drops the command
        send(OP_LD, 16'h0003, 16'h0003, 1'b0, 2);
        drain();
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_MUL;
        cmd_data  = 16'h0020;
        wait_accept(16'h0000, 1'b0, 0, 1'b0);
        repeat (5) @(negedge clk);
        chk("mid_mul_acc", 32'(acc), 32'h0009);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_acc", 32'(acc), 32'd0);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (40) @(negedge clk);
        chk("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
        send(OP_ADD, 16'h0042, 16'h0042, 1'b0, 2);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/acc_sequencer.md
# acc_sequencer

Accumulator control unit that drives the 16-bit combinational ALU (clear / add / subtract / pass-A, 2-bit select) from a command stream. It accepts one command at a time over a valid/ready handshake and sequences the ALU, including a multi-cycle multiply built from repeated ALU adds. It writes each ALU result into the accumulator and returns the new accumulator value over a second valid/ready handshake. It sits between the instruction source and the ALU instance; the parent module wires `alu_a`, `alu_b` and `alu_sel` to the ALU and `alu_out` back.

## Interface
- `W`, 16: datapath width, matching the ALU.
- `KW`, 8: multiplier width; the multiplier is taken from `cmd_data[KW-1:0]`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: the block can accept a command.
- `cmd_op` in 3: opcode. 0 NOP, 1 CLR, 2 ADD, 3 SUB, 4 LD, 5 MUL, 6–7 illegal.
- `cmd_data` in W: operand.
- `rsp_valid` out 1: response held.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_data` out W: accumulator value after the command.
- `rsp_err` out 1: the command was illegal.
- `alu_a` out W: ALU A input.
- `alu_b` out W: ALU B input.
- `alu_sel` out 2: ALU select. 00 clear, 01 add, 10 sub, 11 pass A.
- `alu_out` in W: ALU result, combinational from `alu_a`, `alu_b` and `alu_sel`.
- `acc` out W: current accumulator value.

## Operation
- FSM states are IDLE, EXEC, MUL_ADD and RESP.
- **IDLE:**
  - `cmd_ready` = 1.
  - Drives `alu_sel`=11, `alu_a`=`acc`, `alu_b`=0.
  - On `cmd_valid`&&`cmd_ready` it latches the opcode and operand. MUL also loads `cnt`=`cmd_data[KW-1:0]` and `mcand`=`acc`.
  - Goes to EXEC.
- **EXEC (one cycle):** the block writes `acc`<=`alu_out` with these ALU settings:
  - NOP: sel 11, A=`acc`.
  - CLR: sel 00.
  - ADD: sel 01, A=`acc`, B=`data`.
  - SUB: sel 10, A=`acc`, B=`data`.
  - LD: sel 11, A=`data`.
  - MUL: sel 00, which clears `acc`.
  - Illegal op: sel 11, A=`acc`, so `acc` is unchanged, and the block sets the error flag.
- **After EXEC:**
  - MUL with `cnt`≠0 goes to MUL_ADD.
  - Every other case, including MUL with `cnt`=0, goes to RESP.
- **MUL_ADD:**
  - Each cycle: sel 01, A=`acc`, B=`mcand`, `acc`<=`alu_out`, `cnt`<=`cnt`-1.
  - When the current `cnt`==1, goes to RESP.
- **RESP:**
  - `rsp_valid`=1, `rsp_data`=`acc`, `rsp_err`=flag.
  - These stay stable until `rsp_valid`&&`rsp_ready`, then the block returns to IDLE.
- **Arithmetic:** all results wrap modulo 2^W. MUL gives (`acc` × k) mod 2^16. There are no overflow or borrow flags.
- `cmd_ready`=0 in every state except IDLE. Commands offered in those states are not consumed.

## Timing
- **Reset (any state, including mid-MUL):**
  - The next state is IDLE and `acc`=0.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `cnt`=0, `mcand`=0.
  - Any in-flight command is dropped with no response.
  - `cmd_ready`=0 while `rst`=1, and 1 in the first cycle after release.
- **Single-cycle ops:**
  - Accept edge E0, EXEC during the following cycle, `acc` updates at E1.
  - `rsp_valid` is high from E1.
  - Response latency is 2 edges from accept.
- **MUL with k>0:** the EXEC clear is followed by k MUL_ADD cycles, so `rsp_valid` rises k+2 edges after accept. MUL with k=0 takes 2 edges and responds 0.
- **Back-to-back commands:**
  - The response handshake edge moves the FSM to IDLE.
  - The next command can be accepted on the following edge.
  - Minimum cadence is 3 cycles per single-cycle command when `rsp_ready` is held high.
- **Back-pressure:** `rsp_ready`=0 holds RESP indefinitely, and `acc` does not change while held.
- **ALU combinational path:** `alu_a`, `alu_b` and `alu_sel` are driven from registered state only, with no combinational path from `cmd_*`. `alu_out` is sampled on the same edge it is driven.

## Structure
- The shared package `acc_pkg` holds:
  - the opcode enum (`OP_NOP`…`OP_MUL`);
  - the ALU select constants `ALU_CLR`=00, `ALU_ADD`=01, `ALU_SUB`=10, `ALU_PASS`=11;
  - the FSM state enum.
- No sub-module is needed. The ALU is instantiated by the parent or the testbench, not inside this block.

## Test plan
- Reset, then LD 0x1234 and SUB 0x0235 → responses 0x1234, then 0x0FFF. Each `rsp_valid` is 2 edges after accept.
- LD 0x0001, SUB 0x0002 → 0xFFFF (wrap). Then ADD 0x0001 → 0x0000.
- LD 0x0013, MUL k=0x05 → 0x005F after 7 edges. LD 0x1000, MUL k=0x10 → 0x0000 (wrap). MUL k=0 → 0x0000 after 2 edges.
- Hold `rsp_ready`=0 for 10 cycles after ADD → `rsp_data`/`rsp_err` stable, `cmd_ready`=0, a second `cmd_valid` is not accepted. Release → the second command is accepted on the next IDLE edge.
- `cmd_op`=7 with `acc`=0x00AA → `rsp_err`=1, `rsp_data`=0x00AA. A following NOP → `rsp_err`=0.
- Assert `rst` for one cycle during the 4th MUL_ADD cycle of MUL k=0x20 → no response, `acc`=0, `cmd_ready`=1 on the next cycle.
